// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the wait-state memory.
// FSM encoding, word/counter widths and index sizing.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mips_wait_mem_if.sv
// Processor-to-memory request/response bundle.
// The processor is the master; the memory is the slave.
interface mips_wait_mem_if #(
    parameter int ADDR_W = 32
);
    import mips_mem_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] write_data;
    logic [WORD_W-1:0] read_data;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output mem_read,
        output mem_write,
        output addr,
        output write_data,
        input  read_data,
        input  ready,
        input  busy,
        input  err
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  addr,
        input  write_data,
        output read_data,
        output ready,
        output busy,
        output err
    );

endinterface

// File: rtl/mips_mem_array.sv
// Single-port word storage with a registered, enabled read port.
// Contents are not reset; only the read register is.
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [IW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[idx];
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[idx] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata_q <= '0;
        else      rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips_wait_mem.sv
// Unified instruction/data memory with fixed wait states.
// Requests are latched in IDLE; the array is touched on DONE entry.
module mips_wait_mem
    import mips_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic clk,
    input  logic rst,
    mips_wait_mem_if.slave bus
);

    localparam int IW = idx_w(DEPTH);
    localparam bit ZERO_LAT = (LATENCY == 0);
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    if (LATENCY < 0 || LATENCY > (1 << CNT_W) - 1) begin : g_bad_lat
        $error("mips_wait_mem: LATENCY must be 0..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mips_wait_mem: DEPTH must be a power of two");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              mis_q, mis_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              conflict;
    logic              enter_done;
    logic              arr_we;
    logic              arr_re;
    logic [WORD_W-1:0] arr_rdata;
    logic              unused_addr;

    // Upper address bits wrap away by design.
    assign unused_addr = ^bus.addr[ADDR_W-1:IW+2];

    always_comb begin
        accept   = (state_q == IDLE) &&
                   (bus.mem_read ^ bus.mem_write);
        conflict = (state_q == IDLE) &&
                   bus.mem_read && bus.mem_write;
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        mis_d      = mis_q;
        err_d      = err_q;
        enter_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = bus.addr[IW+1:2];
                    wdata_d = bus.write_data;
                    wr_d    = bus.mem_write;
                    mis_d   = (bus.addr[1:0] != 2'b00);
                    err_d   = 1'b0;
                    if (ZERO_LAT) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else if (conflict) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Misalignment is reported once the access completes.
        if (enter_done && mis_d) err_d = 1'b1;
        ready_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
        arr_we  = enter_done && wr_d;
        arr_re  = enter_done && !wr_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    mips_mem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (idx_d),
        .wdata (wdata_d),
        .rdata (arr_rdata)
    );

    assign bus.read_data = arr_rdata;
    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mips_wait_mem.sv
// Bench for mips_wait_mem: LATENCY=2 and LATENCY=0 instances
// checked against a word-array model of the memory.
module tb_mips_wait_mem;

    localparam int L2 = 2;
    localparam int L0 = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m [2][256];
    bit          v [2][256];
    logic [31:0] last_rd [2];

    mips_wait_mem_if #(.ADDR_W(32)) b2 ();
    mips_wait_mem_if #(.ADDR_W(32)) b0 ();

    mips_wait_mem #(
        .DEPTH(256), .LATENCY(L2), .ADDR_W(32)
    ) u2 (
        .clk(clk), .rst(rst), .bus(b2)
    );

    mips_wait_mem #(
        .DEPTH(256), .LATENCY(L0), .ADDR_W(32)
    ) u0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic int exp_lat(input bit z);
        return (z ? L0 : L2) + 1;
    endfunction

    function automatic logic rdy(input bit z);
        return z ? b0.ready : b2.ready;
    endfunction

    function automatic logic bsy(input bit z);
        return z ? b0.busy : b2.busy;
    endfunction

    function automatic logic er(input bit z);
        return z ? b0.err : b2.err;
    endfunction

    function automatic logic [31:0] rdat(input bit z);
        return z ? b0.read_data : b2.read_data;
    endfunction

    task automatic drive(input bit z, input logic r,
                         input logic w, input logic [31:0] a,
                         input logic [31:0] wd);
        if (z) begin
            b0.mem_read = r; b0.mem_write = w;
            b0.addr = a;     b0.write_data = wd;
        end else begin
            b2.mem_read = r; b2.mem_write = w;
            b2.addr = a;     b2.write_data = wd;
        end
    endtask

    // One complete access; inputs are scrambled after acceptance.
    task automatic access(input bit z, input bit wr,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          output logic [31:0] rd,
                          output int lat, output int bcnt,
                          output logic e);
        int n;
        bit got;
        @(negedge clk);
        drive(z, !wr, wr, a, wd);
        @(posedge clk);
        n = 0; got = 0; bcnt = 0; rd = '0; e = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bsy(z)) bcnt++;
            if (rdy(z)) begin
                got = 1;
                rd = rdat(z);
                e = er(z);
                drive(z, 0, 0, $urandom, $urandom);
            end else begin
                drive(z, !wr, wr, $urandom, $urandom);
            end
        end
        lat = got ? n : -1;
        @(negedge clk);
        if (bsy(z)) bcnt++;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (rdat(k[0]) !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rdata%0d got %h exp 0",
                         k, rdat(k[0]));
            end
            n_tests++;
            if (rdy(k[0]) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready%0d got %b exp 0",
                         k, rdy(k[0]));
            end
            n_tests++;
            if (bsy(k[0]) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy%0d got %b exp 0",
                         k, bsy(k[0]));
            end
            n_tests++;
            if (er(k[0]) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_err%0d got %b exp 0",
                         k, er(k[0]));
            end
            last_rd[k] = 32'h0;
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int lat, bc;
        logic e;
        access(0, 1, 32'h10, 32'hDEADBEEF, rd, lat, bc, e);
        m[0][4] = 32'hDEADBEEF; v[0][4] = 1;
        n_tests++;
        if (lat !== L2 + 1) begin
            n_fail++;
            $display("FAIL wr_lat got %0d exp %0d", lat, L2 + 1);
        end
        n_tests++;
        if (bc !== L2 + 1) begin
            n_fail++;
            $display("FAIL wr_busy got %0d exp %0d", bc, L2 + 1);
        end
        n_tests++;
        if (rd !== last_rd[0]) begin
            n_fail++;
            $display("FAIL wr_keeps_rdata got %h exp %h",
                     rd, last_rd[0]);
        end
        access(0, 0, 32'h10, 32'h0, rd, lat, bc, e);
        last_rd[0] = m[0][4];
        n_tests++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_data got %h exp deadbeef", rd);
        end
        n_tests++;
        if (lat !== L2 + 1) begin
            n_fail++;
            $display("FAIL rd_lat got %0d exp %0d", lat, L2 + 1);
        end
        n_tests++;
        if (bc !== L2 + 1) begin
            n_fail++;
            $display("FAIL rd_busy got %0d exp %0d", bc, L2 + 1);
        end
    endtask

    task automatic test_latency0();
        logic [31:0] rd;
        int lat, bc;
        logic e;
        access(1, 1, 32'h4, 32'h12345678, rd, lat, bc, e);
        m[1][1] = 32'h12345678; v[1][1] = 1;
        n_tests++;
        if (lat !== 1 || bc !== 1) begin
            n_fail++;
            $display("FAIL l0_wr_lat got %0d/%0d exp 1/1", lat, bc);
        end
        access(1, 0, 32'h4, 32'h0, rd, lat, bc, e);
        last_rd[1] = m[1][1];
        n_tests++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL l0_rd_lat got %0d exp 1", lat);
        end
        n_tests++;
        if (rd !== 32'h12345678) begin
            n_fail++;
            $display("FAIL l0_rd_data got %h exp 12345678", rd);
        end
    endtask

    task automatic test_conflict_misalign();
        logic [31:0] rd;
        int lat, bc;
        logic e;
        @(negedge clk);
        drive(0, 1, 1, 32'h10, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (er(0) !== 1'b1 || bsy(0) !== 1'b0 ||
                rdy(0) !== 1'b0) begin
                n_fail++;
                $display("FAIL conflict%0d err/busy/ready %b%b%b exp 100",
                         i, er(0), bsy(0), rdy(0));
            end
        end
        drive(0, 0, 0, 32'h0, 32'h0);
        access(0, 0, 32'h11, 32'h0, rd, lat, bc, e);
        last_rd[0] = m[0][4];
        n_tests++;
        if (rd !== m[0][4]) begin
            n_fail++;
            $display("FAIL misalign_data got %h exp %h", rd, m[0][4]);
        end
        n_tests++;
        if (e !== 1'b1 || lat !== L2 + 1) begin
            n_fail++;
            $display("FAIL misalign_err got %b lat %0d exp 1 lat %0d",
                     e, lat, L2 + 1);
        end
        n_tests++;
        if (er(0) !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky got %b exp 1", er(0));
        end
        access(0, 0, 32'h10, 32'h0, rd, lat, bc, e);
        n_tests++;
        if (e !== 1'b0 || rd !== m[0][4]) begin
            n_fail++;
            $display("FAIL clean_read err %b data %h exp 0 %h",
                     e, rd, m[0][4]);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd, prior;
        int lat, bc;
        logic e;
        prior = $urandom;
        access(0, 1, 32'h20, prior, rd, lat, bc, e);
        m[0][8] = prior; v[0][8] = 1;
        @(negedge clk);
        drive(0, 0, 1, 32'h20, 32'hAAAA5555);
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bsy(0) !== 1'b1) begin
            n_fail++;
            $display("FAIL midwr_busy got %b exp 1", bsy(0));
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bsy(0) !== 1'b0 || rdy(0) !== 1'b0 ||
            er(0) !== 1'b0 || rdat(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL midwr_reset b%b r%b e%b d%h exp 0",
                     bsy(0), rdy(0), er(0), rdat(0));
        end
        drive(0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        access(0, 0, 32'h20, 32'h0, rd, lat, bc, e);
        last_rd[0] = prior;
        n_tests++;
        if (rd !== prior) begin
            n_fail++;
            $display("FAIL midwr_discard got %h exp %h", rd, prior);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        int lat, bc;
        logic e;
        access(0, 1, 32'h400, 32'h0BADF00D, rd, lat, bc, e);
        m[0][0] = 32'h0BADF00D; v[0][0] = 1;
        n_tests++;
        if (e !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_err got %b exp 0", e);
        end
        access(0, 0, 32'h0, 32'h0, rd, lat, bc, e);
        last_rd[0] = m[0][0];
        n_tests++;
        if (rd !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL wrap_data got %h exp 0badf00d", rd);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit got;
        logic [31:0] rd;
        @(negedge clk);
        drive(0, 1, 0, 32'h10, 32'h0);
        @(posedge clk);
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (rdy(0)) got = 1;
        end
        n_tests++;
        if (n !== L2 + 1) begin
            n_fail++;
            $display("FAIL b2b_first got %0d exp %0d", n, L2 + 1);
        end
        @(negedge clk);
        n_tests++;
        if (bsy(0) !== 1'b0 || rdy(0) !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle busy %b ready %b exp 00",
                     bsy(0), rdy(0));
        end
        n = 0; got = 0; rd = '0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (rdy(0)) begin
                got = 1;
                rd = rdat(0);
                drive(0, 0, 0, 32'h0, 32'h0);
            end
        end
        drive(0, 0, 0, 32'h0, 32'h0);
        last_rd[0] = m[0][4];
        n_tests++;
        if (n !== L2 + 1 || rd !== m[0][4]) begin
            n_fail++;
            $display("FAIL b2b_second lat %0d data %h exp %0d %h",
                     n, rd, L2 + 1, m[0][4]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, a;
        int lat, bc, word, off;
        logic e;
        bit z, wr;
        for (int i = 0; i < 60; i++) begin
            z = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            word = $urandom_range(0, 255);
            off = ($urandom_range(0, 3) == 0) ?
                  $urandom_range(1, 3) : 0;
            if (!wr && !v[z][word]) wr = 1;
            wd = $urandom;
            a = ($urandom_range(0, 3) << 10) | (word << 2) | off;
            access(z, wr, a, wd, rd, lat, bc, e);
            n_tests++;
            if (lat !== exp_lat(z) || e !== (off != 0)) begin
                n_fail++;
                $display("FAIL rnd%0d z%0d lat %0d err %b exp %0d %b",
                         i, z, lat, e, exp_lat(z), off != 0);
            end
            if (wr) begin
                m[z][word] = wd; v[z][word] = 1;
                n_tests++;
                if (rd !== last_rd[z]) begin
                    n_fail++;
                    $display("FAIL rnd%0d wr_rdata got %h exp %h",
                             i, rd, last_rd[z]);
                end
            end else begin
                last_rd[z] = m[z][word];
                n_tests++;
                if (rd !== m[z][word]) begin
                    n_fail++;
                    $display("FAIL rnd%0d rd_data a %h got %h exp %h",
                             i, a, rd, m[z][word]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 256; w++) v[k][w] = 0;
        test_reset();
        test_write_read();
        test_latency0();
        test_conflict_misalign();
        test_reset_mid_write();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_wait_mem.md
Name: mips_wait_mem

Overview:
- Unified instruction/data memory with a configurable wait-state latency and a ready handshake.
- Sits directly downstream of the multi-cycle MIPS processor and consumes its memRead/memWrite, address and write-data outputs.
- Returns read data for the IR/MDR path and signals completion so the controller can stall.
- Lets the processor run against slow memory without changes to the datapath.

Parameters:
- DEPTH, 256, number of 32-bit words stored; power of two.
- LATENCY, 2, wait cycles between request acceptance and ready; 0..15.
- ADDR_W, 32, byte-address width from the processor.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  read request (level), held until ready.
- mem_write  in  1  write request (level), held until ready.
- addr  in  ADDR_W  byte address; word index = addr[log2(DEPTH)+1:2].
- write_data  in  32  store data.
- read_data  out  32  registered read result.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high while an access is in flight (WAIT or DONE).
- err  out  1  sticky error flag, cleared by the next accepted access.

Behaviour:
- Reset, async on rst=0: state=IDLE, wait counter=0, read_data=0, ready=0, busy=0, err=0. Storage array is not cleared; its contents are undefined until written.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Exactly one of mem_read/mem_write high → accept. Latch addr, write_data and op; clear err.
  - Go to WAIT with counter=LATENCY-1, or straight to DONE if LATENCY=0.
- WAIT: counter decrements each cycle. At counter=0, go to DONE.
- Entering DONE (same edge):
  - Write: array[idx] <= latched data.
  - Read: read_data <= array[idx].
- DONE: ready=1 for exactly one cycle, busy=1. Next state is IDLE.
- Latency: request seen at edge N → ready high during cycle N+LATENCY+1; read_data valid from that cycle.
- read_data holds its value until the next completed read. Writes never modify read_data.
- busy=1 in WAIT and DONE, 0 in IDLE.
- Inputs changing after acceptance are ignored; only the latched values are used.
- Back-to-back: if a request is still high in the IDLE cycle after DONE, it is accepted as a new access. The controller must drop the request in the ready cycle to avoid a repeat.
- Simultaneous mem_read and mem_write in IDLE:
  - No access; err=1; no state change.
  - Re-evaluated every cycle until resolved.
- Misaligned address (addr[1:0]≠0) at acceptance:
  - Access proceeds on the truncated word index, with normal timing.
  - err=1 in the DONE cycle and held until the next accepted access.
- Address beyond DEPTH: upper bits are ignored and the index wraps modulo DEPTH. Not an error.
- Reset mid-access (WAIT or DONE): abort immediately. A pending write is discarded if DONE has not yet been entered. Return to IDLE with all outputs at reset values.
- Counter width: 4 bits. LATENCY>15 is illegal; the implementation checks this at elaboration.

Decomposition:
- Shared package mips_mem_pkg holds:
  - state encoding (IDLE=2'b00, WAIT=2'b01, DONE=2'b10);
  - WORD_W=32;
  - the counter-width constant;
  - an index-width function derived from DEPTH.
- One sub-module, mips_mem_array: synchronous single-port DEPTH×32 storage with write enable, index and registered read. mips_wait_mem owns the FSM, the latches and the flags.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then 1 → read_data=0, ready=0, busy=0, err=0, with no requests issued.
- Write/read, LATENCY=2:
  - write 0xDEADBEEF to addr 0x10 → ready pulses 3 cycles after acceptance;
  - then read addr 0x10 → read_data=0xDEADBEEF with ready in the same cycle;
  - busy=1 for exactly 3 cycles per access.
- LATENCY=0: read addr 0x4 after writing 0x12345678 → ready in the cycle right after acceptance, read_data=0x12345678.
- Conflict and misalignment:
  - mem_read=mem_write=1 for 2 cycles → err=1, busy=0, no ready.
  - Then read addr 0x11 → data from word 4, err=1 at DONE.
  - Next clean read → err=0.
- Reset mid-write: start write 0xAAAA5555 to 0x20, assert rst in WAIT → outputs reset; a later read of 0x20 returns the prior content, not 0xAAAA5555.
- Wrap and back-to-back:
  - DEPTH=256: write 0x0BADF00D to addr 0x400 → a read at 0x0 returns 0x0BADF00D.
  - mem_read held high across ready → a second access starts in the following IDLE cycle and ready pulses again after LATENCY+1.
